// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the codec ADC receive path.
// Holds the default word width, the receiver state encoding and LRC polarity.
package audio_pkg;

  localparam int AUDIO_DW = 16;

  localparam logic LRC_LEFT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    SHIFT_L,
    PAD_L,
    SHIFT_R,
    PAD_R
  } rx_state_t;

endpackage

// File: rtl/audio_bit_sync.sv
// audio_bit_sync: multi-flop synchronizer for one codec pin.
// Also flags a one-clk strobe on each rising edge of the synchronized level.
module audio_bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/audio_adc_rx.sv
// audio_adc_rx: left-justified codec ADC receiver (codec is bus master).
// Deserializes L/R words on bclk strobes and hands pairs out via valid/ready.
module audio_adc_rx
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH  = AUDIO_DW,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  bclk,
  input  logic                  adclrc,
  input  logic                  adcdat,
  output logic [DATA_WIDTH-1:0] left_sample,
  output logic [DATA_WIDTH-1:0] right_sample,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  rx_state_t             r_state;
  logic [DATA_WIDTH-1:0] r_shift_l;
  logic [DATA_WIDTH-1:0] r_shift_r;
  logic [DATA_WIDTH-1:0] r_left;
  logic [DATA_WIDTH-1:0] r_right;
  logic [CW-1:0]         r_cnt;
  logic                  r_lrc_prev;
  logic                  r_seen;
  logic                  r_pair_done;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  r_frame_err;

  logic w_stb;
  logic w_lrc;
  logic w_dat;
  logic w_bclk_s;
  logic w_lrc_rise;
  logic w_dat_rise;
  logic w_unused;
  logic w_edge;
  logic w_word_end;
  logic [DATA_WIDTH-1:0] w_msb_word;

  audio_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk    (clk),
    .reset  (reset),
    .i_async(bclk),
    .o_sync (w_bclk_s),
    .o_rise (w_stb)
  );

  audio_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrc (
    .clk    (clk),
    .reset  (reset),
    .i_async(adclrc),
    .o_sync (w_lrc),
    .o_rise (w_lrc_rise)
  );

  audio_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
    .clk    (clk),
    .reset  (reset),
    .i_async(adcdat),
    .o_sync (w_dat),
    .o_rise (w_dat_rise)
  );

  assign w_unused   = w_bclk_s ^ w_lrc_rise ^ w_dat_rise;
  // An LRC change only counts once a previous strobe value is known.
  assign w_edge     = r_seen && (w_lrc != r_lrc_prev);
  assign w_word_end = (r_cnt == LAST);
  assign w_msb_word = {{(DATA_WIDTH-1){1'b0}}, w_dat};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift_l   <= '0;
      r_shift_r   <= '0;
      r_cnt       <= '0;
      r_lrc_prev  <= 1'b0;
      r_seen      <= 1'b0;
      r_pair_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_pair_done <= 1'b0;
      if (w_stb) begin
        r_lrc_prev <= w_lrc;
        r_seen     <= 1'b1;
      end
      if (!enable) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          IDLE: r_state <= ALIGN;
          ALIGN: begin
            if (w_stb && w_edge && w_lrc == LRC_LEFT) begin
              r_state   <= SHIFT_L;
              r_shift_l <= w_msb_word;
              r_cnt     <= CW'(1);
            end
          end
          SHIFT_L: begin
            if (w_stb && w_edge) begin
              r_frame_err <= 1'b1;
              if (w_lrc == LRC_LEFT) begin
                r_state   <= SHIFT_L;
                r_shift_l <= w_msb_word;
                r_cnt     <= CW'(1);
              end else begin
                r_state <= ALIGN;
              end
            end else if (w_stb) begin
              r_shift_l <= {r_shift_l[DATA_WIDTH-2:0], w_dat};
              r_cnt     <= r_cnt + CW'(1);
              if (w_word_end) r_state <= PAD_L;
            end
          end
          PAD_L: begin
            if (w_stb && w_edge) begin
              r_state   <= SHIFT_R;
              r_shift_r <= w_msb_word;
              r_cnt     <= CW'(1);
            end
          end
          SHIFT_R: begin
            if (w_stb && w_edge) begin
              r_frame_err <= 1'b1;
              if (w_lrc == LRC_LEFT) begin
                r_state   <= SHIFT_L;
                r_shift_l <= w_msb_word;
                r_cnt     <= CW'(1);
              end else begin
                r_state <= ALIGN;
              end
            end else if (w_stb) begin
              r_shift_r <= {r_shift_r[DATA_WIDTH-2:0], w_dat};
              r_cnt     <= r_cnt + CW'(1);
              if (w_word_end) begin
                r_state     <= PAD_R;
                r_pair_done <= 1'b1;
              end
            end
          end
          PAD_R: begin
            if (w_stb && w_edge) begin
              r_state   <= SHIFT_L;
              r_shift_l <= w_msb_word;
              r_cnt     <= CW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // A finished pair is dropped, not queued, when the held one is unaccepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_left    <= '0;
      r_right   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_pair_done && (!r_valid || sample_ready)) begin
      r_left  <= r_shift_l;
      r_right <= r_shift_r;
      r_valid <= 1'b1;
    end else begin
      if (r_pair_done) r_overrun <= 1'b1;
      if (sample_ready) r_valid <= 1'b0;
    end
  end

  assign left_sample  = r_left;
  assign right_sample = r_right;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;
  assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_audio_adc_rx.sv
// tb_audio_adc_rx: codec-driven directed/random bench for audio_adc_rx.
// A frame-level model predicts which pairs the consumer should accept.
module tb_audio_adc_rx;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          bclk;
  logic          adclrc;
  logic          adcdat;
  logic          sample_ready;
  logic [DW-1:0] left_sample;
  logic [DW-1:0] right_sample;
  logic          sample_valid;
  logic          overrun;
  logic          frame_err;

  int total = 0;
  int bad   = 0;
  int half  = 4;
  int err_cnt = 0;
  int e0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic        m_hold_v;
  logic [31:0] m_hold;
  logic        m_ovr;
  logic [31:0] last_pair;
  logic [31:0] hA;
  logic [31:0] hl;
  logic [31:0] hr;

  always #10 clk = ~clk;

  audio_adc_rx dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bclk        (bclk),
    .adclrc      (adclrc),
    .adcdat      (adcdat),
    .left_sample (left_sample),
    .right_sample(right_sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun     (overrun),
    .frame_err   (frame_err)
  );

  always @(negedge clk) begin
    if (sample_valid === 1'b1 && sample_ready === 1'b1)
      got_q.push_back({left_sample, right_sample});
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag);
    repeat (8) @(posedge clk);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic model_pair(input logic [15:0] l, input logic [15:0] r);
    last_pair = {l, r};
    if (sample_ready) exp_q.push_back({l, r});
    else if (!m_hold_v) begin
      m_hold_v = 1'b1;
      m_hold   = {l, r};
    end else m_ovr = 1'b1;
  endtask

  task automatic bit_out(input logic lrc, input logic d);
    bclk   = 1'b0;
    adclrc = lrc;
    adcdat = d;
    repeat (half) @(posedge clk);
    #1 bclk = 1'b1;
    repeat (half) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic lrc, input logic [31:0] h,
                           input int first, input int n);
    for (int i = first; i < first + n; i++) bit_out(lrc, h[31-i]);
  endtask

  function automatic logic [31:0] mk_half(input logic [15:0] w);
    return {w, 16'($urandom)};
  endfunction

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input bit emit);
    send_bits(1'b1, mk_half(l), 0, 32);
    send_bits(1'b0, mk_half(r), 0, 32);
    if (emit) model_pair(l, r);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; bclk = 1'b0;
    adclrc = 1'b0; adcdat = 1'b0; sample_ready = 1'b1;
    m_hold_v = 1'b0; m_hold = '0; m_ovr = 1'b0; last_pair = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_left", left_sample, 0);
    chk("rst_right", right_sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_ferr", frame_err, 0);

    // basic frames at bclk = clk/8
    @(posedge clk) #1 reset = 1'b0; enable = 1'b1;
    send_bits(1'b0, 32'h0, 0, 32);
    send_frame(16'h1234, 16'hABCD, 1);
    send_frame(16'h1234, 16'hABCD, 1);
    for (int k = 0; k < 3; k++)
      send_frame(16'($urandom), 16'($urandom), 1);
    chk_q("basic");

    // enable drops, outputs hold, then rises mid-left-word
    #1 enable = 1'b0;
    hA = mk_half(16'($urandom));
    send_bits(1'b1, hA, 0, 5);
    chk("hold_pair", {left_sample, right_sample}, last_pair);
    chk("hold_valid", sample_valid, 0);
    enable = 1'b1;
    send_bits(1'b1, hA, 5, 27);
    send_bits(1'b0, mk_half(16'($urandom)), 0, 32);
    send_frame(16'($urandom), 16'($urandom), 1);
    send_frame(16'($urandom), 16'($urandom), 1);
    chk_q("late_en");

    // backpressure: three frames with consumer stalled
    @(posedge clk) #1 sample_ready = 1'b0;
    send_frame(16'h0001, 16'h0002, 1);
    send_frame(16'h0003, 16'h0004, 1);
    send_frame(16'h0005, 16'h0006, 1);
    @(negedge clk);
    chk("bp_valid", sample_valid, 1);
    chk("bp_pair", {left_sample, right_sample}, m_hold);
    chk("bp_ovr", overrun, m_ovr);
    @(posedge clk) #1 sample_ready = 1'b1;
    exp_q.push_back(m_hold);
    m_hold_v = 1'b0;
    chk_q("bp");
    chk("bp_ovr_sticky", overrun, m_ovr);

    // truncated left word
    e0 = err_cnt;
    chk("ferr_none", e0, 0);
    send_bits(1'b1, mk_half(16'($urandom)), 0, 10);
    send_bits(1'b0, mk_half(16'($urandom)), 0, 32);
    send_frame(16'($urandom) | 16'h0100, 16'($urandom), 1);
    chk("ferr_once", err_cnt - e0, 1);
    chk_q("trunc");

    // reset at right bit 7
    hl = mk_half(16'($urandom));
    hr = mk_half(16'($urandom));
    send_bits(1'b1, hl, 0, 32);
    send_bits(1'b0, hr, 0, 7);
    reset = 1'b1;
    m_ovr = 1'b0;
    #1;
    chk("rst2_left", left_sample, 0);
    chk("rst2_right", right_sample, 0);
    chk("rst2_valid", sample_valid, 0);
    chk("rst2_ovr", overrun, m_ovr);
    chk("rst2_ferr", frame_err, 0);
    @(posedge clk) #1 reset = 1'b0;
    send_bits(1'b0, hr, 7, 25);
    send_frame(16'($urandom), 16'($urandom), 1);
    chk_q("post_rst");

    // minimum bclk ratio with extreme values
    half = 2;
    send_frame(16'h8000, 16'h7FFF, 1);
    send_frame(16'($urandom), 16'($urandom), 1);
    send_frame(16'($urandom), 16'($urandom), 1);
    chk_q("fast");
    chk("end_ovr", overrun, m_ovr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_adc_rx.md
AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

Interface
REQ-001 Parameter: DATA_WIDTH, 16, bits per channel word (left-justified codec format).
REQ-002 Parameter: SYNC_STAGES, 2, flip-flop stages on each codec input (minimum 2).
REQ-003 Port: clk, input, 1, system clock, 50 MHz.
REQ-004 Port: reset, input, 1, asynchronous, active-high reset.
REQ-005 Port: enable, input, 1, capture enable, driven by the codec-configuration done signal.
REQ-006 Port: bclk, input, 1, codec bit clock; codec is bus master.
REQ-007 Port: adclrc, input, 1, codec ADC LR clock; 1 = left, 0 = right.
REQ-008 Port: adcdat, input, 1, codec serial ADC data, MSB first.
REQ-009 Port: left_sample, output, DATA_WIDTH, captured left word (two's complement).
REQ-010 Port: right_sample, output, DATA_WIDTH, captured right word.
REQ-011 Port: sample_valid, output, 1, sample pair available.
REQ-012 Port: sample_ready, input, 1, consumer accepts the pair.
REQ-013 Port: overrun, output, 1, sticky; a pair was dropped.
REQ-014 Port: frame_err, output, 1, one-clk pulse; a word was truncated.

Function
REQ-015 bclk, adclrc and adcdat SHALL each pass through SYNC_STAGES flip-flops in the clk domain before use.
REQ-016 A rising edge of synchronized bclk SHALL generate a one-clk strobe; adclrc and adcdat SHALL be sampled only on that strobe.
REQ-017 The block SHALL operate correctly when the bclk period is at least 4 clk periods.
REQ-018 At a strobe where sampled adclrc differs from its value at the previous strobe, the adcdat bit sampled SHALL be the MSB of a new word.
REQ-019 FSM states: IDLE, ALIGN, SHIFT_L, PAD_L, SHIFT_R, PAD_R.
REQ-020 IDLE -> ALIGN when enable = 1; any state -> IDLE when enable = 0, discarding any partial frame.
REQ-021 ALIGN -> SHIFT_L at the strobe where adclrc goes 0->1; that bit is the left MSB.
REQ-022 SHIFT_L SHALL shift one bit per strobe; after DATA_WIDTH bits it SHALL go to PAD_L.
REQ-023 PAD_L SHALL ignore extra bits; on adclrc 1->0 it SHALL go to SHIFT_R with that bit as the right MSB.
REQ-024 SHIFT_R then PAD_R SHALL behave as SHIFT_L then PAD_L with channels swapped; PAD_R -> SHIFT_L on adclrc 0->1.
REQ-025 If adclrc toggles in SHIFT_L or SHIFT_R before DATA_WIDTH bits, the block SHALL pulse frame_err, discard the frame and restart at the new word's MSB: SHIFT_L if adclrc = 1, else ALIGN.
REQ-026 Pair emission: on the clk after the strobe capturing the right LSB, if sample_valid = 0 or sample_ready = 1, left_sample/right_sample SHALL load both words and sample_valid SHALL be 1.
REQ-027 sample_valid SHALL stay high, with stable data, until sampled with sample_ready = 1; it SHALL then clear unless a new pair loads in the same cycle.
REQ-028 If a pair completes while sample_valid = 1 and sample_ready = 0, the new pair SHALL be dropped, the held pair kept, and overrun set until reset.
REQ-029 With enable = 0, outputs SHALL hold their last values; sample_valid SHALL still clear on acceptance.

Reset
REQ-030 Reset SHALL force state IDLE, both shift registers 0, left_sample = 0, right_sample = 0, sample_valid = 0, overrun = 0, frame_err = 0, and all synchronizer flops 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; after release a full ALIGN is required before any emission.

Structure
REQ-032 Shared package audio_pkg SHALL hold the DATA_WIDTH default, the FSM state enum and the codec LRC polarity constant.
REQ-033 The synchronizer plus rising-edge strobe SHALL be a sub-module named audio_bit_sync, instantiated once per codec input.

Verification
REQ-034 Codec model, bclk = clk/8, 32 bclk per LRC half, left 0x1234, right 0xABCD, sample_ready = 1 -> one sample_valid pulse per frame with left_sample = 0x1234 and right_sample = 0xABCD.
REQ-035 enable rises mid-left-word -> no emission until after the next adclrc 0->1 edge; the first emitted pair is the next complete frame.
REQ-036 sample_ready = 0 for 3 frames with values 0x0001/0x0002, 0x0003/0x0004, 0x0005/0x0006 -> pair 0x0001/0x0002 held, overrun = 1, and on ready, 0x0001/0x0002 is accepted.
REQ-037 adclrc toggles after 10 left bits -> frame_err pulses once, no pair is emitted for that frame, and the next full frame is emitted correctly.
REQ-038 Reset asserted at right bit 7 -> all outputs 0 within the same clk cycle; after release, the first pair requires a fresh ALIGN.
REQ-039 Values 0x8000/0x7FFF at bclk = clk/4 -> captured exactly, confirming the MSB position and the minimum bclk ratio.
